cond_unit: RTL and testbench

- Parametrised successor to the single-bank conditional-execution logic.
- Holds NBANKS independent NZCV flag banks and evaluates the 4-bit condition against the selected bank.
- Gates pc_src/reg_write/mem_write, and now also mem_write, by the condition result.
- Adds an IT-block sequencer that supplies the condition for up to IT_MAX following instructions. Sits between the decoder and the datapath write enables.

---
 rtl/cond_unit.sv | 176 +++++++++++++++++
 tb/tb_cond_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Conditional-execution unit: NBANKS NZCV flag banks, condition evaluation, write-enable gating and an IT-block sequencer.
// Optional squashed-instruction counter enabled by defining COND_SQUASH_CNT_EN.
module cond_unit #(
  parameter int NBANKS = 2,
  parameter int IT_MAX = 4,
  parameter int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  parameter int LW     = $clog2(IT_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  pcs,
  input  logic                  reg_w,
  input  logic                  mem_w,
  input  logic                  no_write,
  input  logic [1:0]            flag_w,
  input  logic [3:0]            cond,
  input  logic [BW-1:0]         bank_sel,
  input  logic [3:0]            alu_flag,
  input  logic                  it_start,
  input  logic [3:0]            it_cond,
  input  logic [IT_MAX-1:0]     it_mask,
  input  logic [LW-1:0]         it_len,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  cond_ex,
  output logic                  it_active,
  output logic                  it_err,
  output logic [4*NBANKS-1:0]   flags_q,
  output logic [15:0]           squash_cnt
);
  localparam int IW = (IT_MAX > 1) ? $clog2(IT_MAX) : 1;
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [LW-1:0]     count_q, count_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [3:0]        it_cond_q, it_cond_d;
  logic [IT_MAX-1:0] mask_q, mask_d;
  logic              err_q, err_d;
  logic              active, bad_len, upd;
  logic [3:0]        ec, sel_flags;
  wire  [4*NBANKS-1:0] flags_d;

  assign active = (state_q == S_ACTIVE);

  // Inside an IT block the per-slot condition replaces the instruction's own field.
  always_comb begin
    ec = cond;
    if (active && !it_start) begin
      if (it_cond_q == 4'b1110) ec = it_cond_q;
      else ec = {it_cond_q[3:1], it_cond_q[0] ^ ~mask_q[idx_q]};
    end
  end

  always_comb begin
    sel_flags = 4'b0000;
    for (int b = 0; b < NBANKS; b++) begin
      if (bank_sel == BW'(b)) sel_flags = flags_q[4*b +: 4];
    end
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = sel_flags;
    case (ec)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = ~z & c;
      4'b1001: cond_ex = z | ~c;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign upd       = valid & cond_ex & ~it_start;
  assign pc_src    = upd & pcs;
  assign reg_write = upd & reg_w & ~no_write;
  assign mem_write = upd & mem_w;

  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic hit;
      assign hit = upd & (bank_sel == BW'(gi));
      assign flags_d[4*gi+3 -: 2] = (hit & flag_w[1]) ? alu_flag[3:2] : flags_q[4*gi+3 -: 2];
      assign flags_d[4*gi+1 -: 2] = (hit & flag_w[0]) ? alu_flag[1:0] : flags_q[4*gi+1 -: 2];
    end
  endgenerate

  // Every valid instruction in a block uses one slot, including a rejected nested IT.
  always_comb begin
    count_d   = count_q;
    idx_d     = idx_q;
    it_cond_d = it_cond_q;
    mask_d    = mask_q;
    err_d     = 1'b0;
    bad_len   = (it_len == '0) || (it_len > LW'(IT_MAX));
    if (valid) begin
      if (active) begin
        if (it_start) err_d = 1'b1;
        if (pc_src || count_q == LW'(1)) begin
          count_d = '0;
          idx_d   = '0;
        end else begin
          count_d = count_q - LW'(1);
          idx_d   = idx_q + IW'(1);
        end
      end else if (it_start) begin
        if (bad_len) begin
          err_d = 1'b1;
        end else begin
          count_d   = it_len;
          idx_d     = '0;
          it_cond_d = it_cond;
          mask_d    = it_mask;
        end
      end
    end
  end

  assign state_d = (count_d != '0) ? S_ACTIVE : S_IDLE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      it_cond_q <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      it_cond_q <= it_cond_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
      flags_q   <= flags_d;
    end
  end

  assign it_active = active;
  assign it_err    = err_q;

`ifdef COND_SQUASH_CNT_EN
  logic [15:0] squash_q, squash_d;

  always_comb begin
    squash_d = squash_q;
    if (valid && !cond_ex && !it_start && squash_q != 16'hFFFF) squash_d = squash_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) squash_q <= 16'h0000;
    else        squash_q <= squash_d;
  end

  assign squash_cnt = squash_q;
`else
  assign squash_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_cond_unit;
  localparam int NB  = 2;
  localparam int ITM = 4;
  localparam int BW  = 1;
  localparam int LW  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            valid, pcs, reg_w, mem_w, no_write, it_start;
  logic [1:0]      flag_w;
  logic [3:0]      cond, alu_flag, it_cond;
  logic [BW-1:0]   bank_sel;
  logic [ITM-1:0]  it_mask;
  logic [LW-1:0]   it_len;
  logic            pc_src, reg_write, mem_write, cond_ex, it_active, it_err;
  logic [4*NB-1:0] flags_q;
  logic [15:0]     squash_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit verbose = 1'b1;

  // Reference state: flags per bank, pending per-slot conditions of the open IT block.
  logic [3:0]  m_flags [NB];
  logic [3:0]  m_q [$];
  logic        m_err;
  logic [15:0] m_sq;

  cond_unit #(.NBANKS(NB), .IT_MAX(ITM)) dut (
    .clk(clk), .reset(reset), .valid(valid), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
    .no_write(no_write), .flag_w(flag_w), .cond(cond), .bank_sel(bank_sel),
    .alu_flag(alu_flag), .it_start(it_start), .it_cond(it_cond), .it_mask(it_mask),
    .it_len(it_len), .pc_src(pc_src), .reg_write(reg_write), .mem_write(mem_write),
    .cond_ex(cond_ex), .it_active(it_active), .it_err(it_err), .flags_q(flags_q),
    .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ARM-style: base test selected by cond[3:1], inverted by cond[0]; 1110 always, 1111 never.
  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy & ~z;
      3'd5: base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_flags[b] = 4'h0;
    m_q.delete();
    m_err = 1'b0;
    m_sq  = 16'h0;
  endtask

  function automatic logic [3:0] exp_ec();
    if (m_q.size() != 0 && !it_start) return m_q[0];
    return cond;
  endfunction

  task automatic compare();
    logic ce;
    logic [4*NB-1:0] ef;
    logic [15:0] esq;
    ce = cond_true(exp_ec(), m_flags[bank_sel]);
    for (int b = 0; b < NB; b++) ef[4*b +: 4] = m_flags[b];
`ifdef COND_SQUASH_CNT_EN
    esq = m_sq;
`else
    esq = 16'h0;
`endif
    chk("cond_ex",    64'(cond_ex),    64'(ce));
    chk("pc_src",     64'(pc_src),     64'(valid & pcs & ce & ~it_start));
    chk("reg_write",  64'(reg_write),  64'(valid & reg_w & ce & ~no_write & ~it_start));
    chk("mem_write",  64'(mem_write),  64'(valid & mem_w & ce & ~it_start));
    chk("it_active",  64'(it_active),  64'(m_q.size() != 0));
    chk("it_err",     64'(it_err),     64'(m_err));
    chk("flags_q",    64'(flags_q),    64'(ef));
    chk("squash_cnt", 64'(squash_cnt), 64'(esq));
  endtask

  task automatic model_step();
    logic act, ce;
    act = (m_q.size() != 0);
    ce  = cond_true(exp_ec(), m_flags[bank_sel]);
    m_err = 1'b0;
    if (valid) begin
      if (ce && !it_start) begin
        if (flag_w[1]) m_flags[bank_sel][3:2] = alu_flag[3:2];
        if (flag_w[0]) m_flags[bank_sel][1:0] = alu_flag[1:0];
      end
      if (!ce && !it_start && m_sq != 16'hFFFF) m_sq = m_sq + 16'd1;
      if (act) begin
        if (it_start) m_err = 1'b1;
        if (pcs && ce && !it_start) m_q.delete();
        else void'(m_q.pop_front());
      end else if (it_start) begin
        if (it_len == 0 || it_len > ITM) m_err = 1'b1;
        else begin
          for (int i = 0; i < int'(it_len); i++)
            m_q.push_back((it_cond == 4'hE) ? 4'hE : {it_cond[3:1], it_cond[0] ^ ~it_mask[i]});
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    if (verbose)
      $display("t=%0t v=%b cond=%h bank=%0d its=%b len=%0d ce=%b pc=%b rw=%b mw=%b act=%b err=%b flags=%h sq=%0d",
               $time, valid, cond, bank_sel, it_start, it_len, cond_ex, pc_src, reg_write,
               mem_write, it_active, it_err, flags_q, squash_cnt);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid = 0; pcs = 0; reg_w = 0; mem_w = 0; no_write = 0; it_start = 0;
    flag_w = 0; cond = 4'hE; alu_flag = 0; it_cond = 0; it_mask = 0; it_len = 0; bank_sel = 0;
  endtask

  initial begin
    logic [15:0] sq3;
`ifdef COND_SQUASH_CNT_EN
    sq3 = 16'd3;
`else
    sq3 = 16'd0;
`endif
    clear_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 64'(flags_q), 64'h0);
    chk("rst_it_active", 64'(it_active), 64'h0);
    chk("rst_it_err", 64'(it_err), 64'h0);
    chk("rst_squash", 64'(squash_cnt), 64'h0);
    reset = 1'b1;

    // ADDS-like flag write to bank 0
    valid = 1; cond = 4'hE; flag_w = 2'b11; alu_flag = 4'b0100; reg_w = 1;
    cycle();
    chk("adds_bank0", 64'(flags_q[3:0]), 64'h4);
    flag_w = 0; cond = 4'h0; #1;
    chk("eq_reg_write", 64'(reg_write), 64'h1);
    cycle();
    cond = 4'h1; #1;
    chk("ne_reg_write", 64'(reg_write), 64'h0);
    cycle();

    // C,V-only write to bank 1
    bank_sel = 1; flag_w = 2'b01; alu_flag = 4'hF; cond = 4'hE; reg_w = 0;
    cycle();
    chk("bank1_cv", 64'(flags_q[7:4]), 64'h3);
    chk("bank0_kept", 64'(flags_q[3:0]), 64'h4);
    flag_w = 0; cond = 4'hF; #1;
    chk("never_cond", 64'(cond_ex), 64'h0);
    cycle();

    // IT EQ, len 3, mask 101, with a two-cycle stall mid-block
    bank_sel = 0; it_start = 1; it_cond = 4'h0; it_len = 3; it_mask = 4'b0101; cond = 4'hE;
    cycle();
    chk("it_started", 64'(it_active), 64'h1);
    it_start = 0; reg_w = 1; #1;
    chk("it_slot0", 64'(cond_ex), 64'h1);
    cycle();
    valid = 0; cycle(); cycle();
    valid = 1; #1;
    chk("it_slot1", 64'(cond_ex), 64'h0);
    cycle();
    chk("it_still_active", 64'(it_active), 64'h1);
    chk("it_slot2", 64'(cond_ex), 64'h1);
    cycle();
    chk("it_done", 64'(it_active), 64'h0);

    // IT len 4, branch taken on second slot
    it_start = 1; it_cond = 4'h0; it_len = 4; it_mask = 4'hF; reg_w = 0;
    cycle();
    it_start = 0; cycle();
    pcs = 1; #1;
    chk("it_branch_pc", 64'(pc_src), 64'h1);
    cycle();
    chk("it_branch_exit", 64'(it_active), 64'h0);
    pcs = 0;

    // Bad IT length
    it_start = 1; it_len = 0;
    cycle();
    chk("badlen_err", 64'(it_err), 64'h1);
    it_start = 0; valid = 0;
    cycle();
    chk("badlen_pulse", 64'(it_err), 64'h0);

    // Nested IT start
    valid = 1; it_start = 1; it_cond = 4'hE; it_len = 2; it_mask = 0;
    cycle();
    reg_w = 1; mem_w = 1; pcs = 1; #1;
    chk("nested_no_rw", 64'(reg_write), 64'h0);
    chk("nested_no_mw", 64'(mem_write), 64'h0);
    cycle();
    chk("nested_err", 64'(it_err), 64'h1);
    chk("nested_slot_used", 64'(it_active), 64'h1);
    it_start = 0; pcs = 0;
    cycle();
    chk("nested_done", 64'(it_active), 64'h0);

    // Randomized traffic
    verbose = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      valid    = ($urandom_range(0, 99) < 85);
      pcs      = ($urandom_range(0, 99) < 10);
      reg_w    = 1'($urandom);
      mem_w    = 1'($urandom);
      no_write = ($urandom_range(0, 99) < 20);
      flag_w   = 2'($urandom);
      cond     = 4'($urandom);
      bank_sel = BW'($urandom_range(0, NB - 1));
      alu_flag = 4'($urandom);
      it_start = ($urandom_range(0, 99) < 12);
      it_cond  = ($urandom_range(0, 99) < 15) ? 4'hE : 4'($urandom);
      it_mask  = ITM'($urandom);
      it_len   = LW'($urandom_range(0, 7));
      cycle();
    end
    verbose = 1'b1;

    // Reset asserted in the middle of an IT block
    clear_in();
    valid = 1; flag_w = 2'b11; alu_flag = 4'hA; bank_sel = 1;
    cycle();
    flag_w = 0; it_start = 1; it_cond = 4'h2; it_len = 4; it_mask = 4'hF;
    cycle();
    it_start = 0;
    cycle();
    chk("mid_it_active", 64'(it_active), 64'h1);
    reset = 1'b0; #1;
    chk("mid_rst_active", 64'(it_active), 64'h0);
    chk("mid_rst_flags", 64'(flags_q), 64'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    // Three squashed instructions
    clear_in();
    valid = 1; cond = 4'hF;
    cycle(); cycle(); cycle();
    chk("squash3", 64'(squash_cnt), 64'(sq3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
